// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared core constants, the writeback request record and a
//             register one-hot helper used by the writeback stage.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   // One writeback request: destination register plus result value.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   // One-hot mask for register r; x0 maps to an all-zero mask so it can
   // never be marked busy.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
      logic [NUM_REGS-1:0] v;
      v = '0;
      if (r != '0) begin
         v[r] = 1'b1;
      end
      return v;
   endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Brief    : Small synchronous FIFO with valid/ready on both sides and an
//             occupancy count. Push and pop may coincide when non-empty;
//             ready on the push side depends on stored state only.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push_valid,
   output logic                       o_push_ready,
   input  logic [WIDTH-1:0]           i_push_data,
   output logic                       o_pop_valid,
   input  logic                       i_pop_ready,
   output logic [WIDTH-1:0]           o_pop_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic               w_push;
   logic               w_pop;

   assign o_push_ready = (r_count != c_CNT_W'(DEPTH));
   assign o_pop_valid  = (r_count != '0);
   assign o_pop_data   = r_mem[r_rd_ptr];
   assign o_count      = r_count;

   assign w_push = i_push_valid && o_push_ready;
   assign w_pop  = o_pop_valid  && i_pop_ready;

   // Storage array: written on push, no reset needed since count guards reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers wrap at DEPTH; occupancy tracks push/pop independently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Brief    : Writeback stage feeding the register file's single write port.
//             Merges ALU results with queued load responses (bounded load
//             bursts so the ALU is never starved), registers the winner with
//             one cycle of latency and keeps a per-register load scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
   import riscv_pkg::*;
#(
   parameter int LQ_DEPTH  = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alu_valid,
   output logic                alu_ready,
   input  logic [REG_AW-1:0]   alu_rd,
   input  logic [XLEN-1:0]     alu_data,
   input  logic                lsu_valid,
   output logic                lsu_ready,
   input  logic [REG_AW-1:0]   lsu_rd,
   input  logic [XLEN-1:0]     lsu_data,
   input  logic                issue_valid,
   input  logic [REG_AW-1:0]   issue_rd,
   output logic [NUM_REGS-1:0] busy,
   output logic                wb_we,
   output logic [REG_AW-1:0]   wb_rd,
   output logic [XLEN-1:0]     wb_data
);

   localparam int c_BURST_W = $clog2(MAX_BURST+1);
   localparam int c_LQCNT_W = $clog2(LQ_DEPTH+1);

   wb_req_t                w_lsu_req;
   wb_req_t                w_alu_req;
   wb_req_t                w_lq_head;
   wb_req_t                w_win;
   logic                   w_lq_valid;
   logic [c_LQCNT_W-1:0]   w_lq_count;
   logic                   w_unused_lq;

   logic                   w_load_grant;
   logic                   w_alu_grant;
   logic [c_BURST_W-1:0]   w_burst_nxt;
   logic [NUM_REGS-1:0]    w_busy_set;
   logic [NUM_REGS-1:0]    w_busy_clr;

   logic [c_BURST_W-1:0]   r_burst;
   logic [NUM_REGS-1:0]    r_busy;
   logic                   r_wb_we;
   logic [REG_AW-1:0]      r_wb_rd;
   logic [XLEN-1:0]        r_wb_data;

   assign w_lsu_req = '{rd: lsu_rd, data: lsu_data};
   assign w_alu_req = '{rd: alu_rd, data: alu_data};

   // Load response queue; the arbiter only needs its empty/full view, so
   // the occupancy count is folded into a sink.
   wb_fifo #(
      .DEPTH (LQ_DEPTH),
      .WIDTH ($bits(wb_req_t))
   ) u_lq (
      .clk          (clk),
      .rst          (rst),
      .i_push_valid (lsu_valid),
      .o_push_ready (lsu_ready),
      .i_push_data  (w_lsu_req),
      .o_pop_valid  (w_lq_valid),
      .i_pop_ready  (w_load_grant),
      .o_pop_data   (w_lq_head),
      .o_count      (w_lq_count)
   );

   assign w_unused_lq = ^w_lq_count;

   // Pick one winner per cycle: loads first until the burst limit is hit
   // while an ALU result waits; ALU readiness never looks at lsu_valid.
   always_comb begin
      w_load_grant = w_lq_valid && (!alu_valid || (r_burst < c_BURST_W'(MAX_BURST)));
      w_alu_grant  = alu_valid  && (!w_lq_valid || (r_burst == c_BURST_W'(MAX_BURST)));
      w_burst_nxt  = '0;
      if (w_load_grant && alu_valid) begin
         w_burst_nxt = r_burst + 1'b1;
      end
      w_win = w_load_grant ? w_lq_head : w_alu_req;
   end

   assign alu_ready = w_alu_grant;

   // Scoreboard updates: issue sets, load writeback clears, set wins a tie.
   always_comb begin
      w_busy_set = issue_valid  ? reg_onehot(issue_rd)     : '0;
      w_busy_clr = w_load_grant ? reg_onehot(w_lq_head.rd) : '0;
   end

   // Burst counter and scoreboard state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_burst <= '0;
         r_busy  <= '0;
      end else begin
         r_burst <= w_burst_nxt;
         r_busy  <= (r_busy & ~w_busy_clr) | w_busy_set;
      end
   end

   // Writeback register: x0 results are consumed but never enable a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_we   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else if (w_load_grant || w_alu_grant) begin
         r_wb_we   <= (w_win.rd != '0);
         r_wb_rd   <= w_win.rd;
         r_wb_data <= w_win.data;
      end else begin
         r_wb_we   <= 1'b0;
      end
   end

   assign busy    = r_busy;
   assign wb_we   = r_wb_we;
   assign wb_rd   = r_wb_rd;
   assign wb_data = r_wb_data;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Brief    : Directed, table-driven bench for wb_arbiter with hand-computed
//             per-cycle expectations, plus an asynchronous reset sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [31:0] busy;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   always #5 clk = ~clk;

   wb_arbiter #(.LQ_DEPTH(2), .MAX_BURST(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .busy        (busy),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data)
   );

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic        iv;
      logic [4:0]  ird;
      logic        ear;
      logic        elr;
      logic        ewe;
      logic [4:0]  erd;
      logic [31:0] edata;
      logic [31:0] ebusy;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ird,
                      input logic ear, input logic elr,
                      input logic ewe, input logic [4:0] erd, input logic [31:0] edata,
                      input logic [31:0] ebusy);
      vec_t v;
      v.av = av;   v.ard = ard;  v.ad = ad;
      v.lv = lv;   v.lrd = lrd;  v.ld = ld;
      v.iv = iv;   v.ird = ird;
      v.ear = ear; v.elr = elr;
      v.ewe = ewe; v.erd = erd;  v.edata = edata; v.ebusy = ebusy;
      vecs.push_back(v);
   endtask

   task automatic drive_idle();
      alu_valid   = 1'b0; alu_rd   = '0; alu_data = '0;
      lsu_valid   = 1'b0; lsu_rd   = '0; lsu_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //   alu v/rd/data        lsu v/rd/data        iss v/rd  ar lr  we rd  data          busy
      // ALU only
      add(1, 5, 32'hDEADBEEF, 0,  0, 32'h0,    0, 0,  1, 1,  1,  5, 32'hDEADBEEF, 32'h0);
      add(0, 0, 32'h0,        0,  0, 32'h0,    0, 0,  0, 1,  0,  5, 32'hDEADBEEF, 32'h0);
      // Scoreboard set/clear, set-wins
      add(0, 0, 32'h0,        0,  0, 32'h0,    1, 7,  0, 1,  0,  5, 32'hDEADBEEF, 32'h80);
      add(0, 0, 32'h0,        1,  7, 32'h1234, 0, 0,  0, 1,  0,  5, 32'hDEADBEEF, 32'h80);
      add(0, 0, 32'h0,        0,  0, 32'h0,    0, 0,  0, 1,  1,  7, 32'h1234,     32'h0);
      add(0, 0, 32'h0,        0,  0, 32'h0,    1, 7,  0, 1,  0,  7, 32'h1234,     32'h80);
      add(0, 0, 32'h0,        1,  7, 32'h5678, 0, 0,  0, 1,  0,  7, 32'h1234,     32'h80);
      add(0, 0, 32'h0,        0,  0, 32'h0,    1, 7,  0, 1,  1,  7, 32'h5678,     32'h80);
      add(0, 0, 32'h0,        1,  7, 32'h9ABC, 0, 0,  0, 1,  0,  7, 32'h5678,     32'h80);
      add(0, 0, 32'h0,        0,  0, 32'h0,    0, 0,  0, 1,  1,  7, 32'h9ABC,     32'h0);
      // Back-to-back pushes with ALU idle
      add(0, 0, 32'h0,        1,  1, 32'h11,   0, 0,  0, 1,  0,  7, 32'h9ABC,     32'h0);
      add(0, 0, 32'h0,        1,  2, 32'h22,   0, 0,  0, 1,  1,  1, 32'h11,       32'h0);
      add(0, 0, 32'h0,        1,  3, 32'h33,   0, 0,  0, 1,  1,  2, 32'h22,       32'h0);
      add(0, 0, 32'h0,        0,  0, 32'h0,    0, 0,  0, 1,  1,  3, 32'h33,       32'h0);
      add(0, 0, 32'h0,        0,  0, 32'h0,    0, 0,  0, 1,  0,  3, 32'h33,       32'h0);
      // Starvation guard: 4 loads, 1 ALU, queue fills, loads resume
      add(0, 0, 32'h0,        1, 11, 32'hB0,   0, 0,  0, 1,  0,  3, 32'h33,       32'h0);
      add(1,10, 32'hA0,       1, 12, 32'hB1,   0, 0,  0, 1,  1, 11, 32'hB0,       32'h0);
      add(1,10, 32'hA0,       1, 13, 32'hB2,   0, 0,  0, 1,  1, 12, 32'hB1,       32'h0);
      add(1,10, 32'hA0,       1, 14, 32'hB3,   0, 0,  0, 1,  1, 13, 32'hB2,       32'h0);
      add(1,10, 32'hA0,       1, 15, 32'hB4,   0, 0,  0, 1,  1, 14, 32'hB3,       32'h0);
      add(1,10, 32'hA0,       1, 16, 32'hB5,   0, 0,  1, 1,  1, 10, 32'hA0,       32'h0);
      add(1,17, 32'hC0,       1, 18, 32'hB6,   0, 0,  0, 0,  1, 15, 32'hB4,       32'h0);
      add(1,17, 32'hC0,       1, 18, 32'hB6,   0, 0,  0, 1,  1, 16, 32'hB5,       32'h0);
      add(1,17, 32'hC0,       0,  0, 32'h0,    0, 0,  0, 1,  1, 18, 32'hB6,       32'h0);
      add(1,17, 32'hC0,       0,  0, 32'h0,    0, 0,  1, 1,  1, 17, 32'hC0,       32'h0);
      add(0, 0, 32'h0,        0,  0, 32'h0,    0, 0,  0, 1,  0, 17, 32'hC0,       32'h0);
      // x0 results from both sources
      add(1, 0, 32'hF0,       0,  0, 32'h0,    0, 0,  1, 1,  0,  0, 32'hF0,       32'h0);
      add(0, 0, 32'h0,        1,  0, 32'hF1,   0, 0,  0, 1,  0,  0, 32'hF0,       32'h0);
      add(0, 0, 32'h0,        0,  0, 32'h0,    1, 0,  0, 1,  0,  0, 32'hF1,       32'h0);
      // Build two queued loads with busy=0x0C ahead of the reset sequence
      add(0, 0, 32'h0,        0,  0, 32'h0,    1, 2,  0, 1,  0,  0, 32'hF1,       32'h04);
      add(0, 0, 32'h0,        1, 20, 32'hD0,   1, 3,  0, 1,  0,  0, 32'hF1,       32'h0C);
      add(1,21, 32'hE0,       1, 22, 32'hD1,   0, 0,  0, 1,  1, 20, 32'hD0,       32'h0C);
      add(1,21, 32'hE0,       1, 23, 32'hD2,   0, 0,  0, 1,  1, 22, 32'hD1,       32'h0C);
      add(1,21, 32'hE0,       1, 24, 32'hD3,   0, 0,  0, 1,  1, 23, 32'hD2,       32'h0C);
      add(1,21, 32'hE0,       1, 25, 32'hD4,   0, 0,  0, 1,  1, 24, 32'hD3,       32'h0C);
      add(1,21, 32'hE0,       1, 26, 32'hD5,   0, 0,  1, 1,  1, 21, 32'hE0,       32'h0C);

      // Reset state
      rst = 1'b0;
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      check("reset wb_we",     32'(wb_we),     32'h0);
      check("reset wb_rd",     32'(wb_rd),     32'h0);
      check("reset wb_data",   wb_data,        32'h0);
      check("reset busy",      busy,           32'h0);
      check("reset lsu_ready", 32'(lsu_ready), 32'h1);
      check("reset alu_ready", 32'(alu_ready), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         alu_valid   = vecs[i].av; alu_rd   = vecs[i].ard; alu_data = vecs[i].ad;
         lsu_valid   = vecs[i].lv; lsu_rd   = vecs[i].lrd; lsu_data = vecs[i].ld;
         issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
         #1;
         check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
         check($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].elr));
         @(posedge clk);
         #1;
         check($sformatf("v%0d wb_we", i),   32'(wb_we), 32'(vecs[i].ewe));
         check($sformatf("v%0d wb_rd", i),   32'(wb_rd), 32'(vecs[i].erd));
         check($sformatf("v%0d wb_data", i), wb_data,    vecs[i].edata);
         check($sformatf("v%0d busy", i),    busy,       vecs[i].ebusy);
      end

      // Asynchronous reset with a full queue and pending offers
      @(negedge clk);
      alu_valid = 1'b1; alu_rd = 5'd27; alu_data = 32'hE1;
      lsu_valid = 1'b1; lsu_rd = 5'd28; lsu_data = 32'hD6;
      #1;
      check("prereset lsu_ready", 32'(lsu_ready), 32'h0);
      check("prereset busy",      busy,           32'h0C);
      #1;
      rst = 1'b0;
      #1;
      check("async wb_we",     32'(wb_we),     32'h0);
      check("async wb_rd",     32'(wb_rd),     32'h0);
      check("async wb_data",   wb_data,        32'h0);
      check("async busy",      busy,           32'h0);
      check("async lsu_ready", 32'(lsu_ready), 32'h1);
      @(negedge clk);
      drive_idle();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("postreset%0d wb_we", k),     32'(wb_we),     32'h0);
         check($sformatf("postreset%0d busy", k),      busy,           32'h0);
         check($sformatf("postreset%0d lsu_ready", k), 32'(lsu_ready), 32'h1);
         check($sformatf("postreset%0d alu_ready", k), 32'(alu_ready), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_wb_arbiter
`default_nettype wire
